// File: rtl/audio_adc_rx.sv
// audio_adc_rx: WM8731 ADC I2S receiver. The codec is the bus master; this
// block oversamples AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT on clk and rebuilds
// left/right words (MSB first, one-bit I2S delay after each LRCK edge).
// Complete stereo pairs are handed to the recorder with a valid/ready
// handshake. A pair that arrives while the previous one is still unread is
// dropped, and the sticky ovf flag is raised.
//
// Optional feature: define AUDIO_ADC_RX_MONO_EN to build the mono mix
// (signed average of left and right). Without it o_mono is tied to 0.
//
// Ports:
//   clk, reset            system clock (>= 4x BCLK), async active-low reset
//   en                    capture enable (recorder in RECORDING)
//   AUD_BCLK/ADCLRCK/ADCDAT  codec pins, asynchronous to clk
//   o_left/o_right/o_mono    last delivered pair (+ mono mix)
//   o_valid, i_ready         pair handshake
//   ovf, ovf_clr             sticky overflow flag and its synchronous clear
//
// Capture FSM states:
//   state    | meaning
//   ST_IDLE  | no LRCK edge seen since reset
//   ST_SHIFT | word in progress, collecting bits
//   ST_FULL  | word complete, extra bits ignored until next LRCK edge
module audio_adc_rx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic [DATA_W-1:0] o_mono,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FULL} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DATA_W - 1);

  logic r_bclk_s1, r_bclk_s2, r_bclk_prev;
  logic r_lrck_s1, r_lrck_s2, r_lrck_last;
  logic r_dat_s1, r_dat_s2;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_chan;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_left_hold;
  logic [DATA_W-1:0] r_right_hold;
  logic              r_left_ok;
  logic              r_armed;
  logic              r_pair_pend;

  logic              w_bclk_rise;
  logic              w_lrck_edge;
  logic [DATA_W-1:0] w_word;
  logic              w_load;
  logic              w_ovf_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_prev <= 1'b0;
      r_lrck_s1   <= 1'b0;
      r_lrck_s2   <= 1'b0;
      r_dat_s1    <= 1'b0;
      r_dat_s2    <= 1'b0;
    end else begin
      r_bclk_s1   <= AUD_BCLK;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_prev <= r_bclk_s2;
      r_lrck_s1   <= AUD_ADCLRCK;
      r_lrck_s2   <= r_lrck_s1;
      r_dat_s1    <= AUD_ADCDAT;
      r_dat_s2    <= r_dat_s1;
    end
  end

  assign w_bclk_rise = r_bclk_s2 & ~r_bclk_prev;
  assign w_lrck_edge = r_lrck_s2 ^ r_lrck_last;
  assign w_word      = {r_shift[DATA_W-2:0], r_dat_s2};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_chan       <= 1'b0;
      r_shift      <= '0;
      r_left_hold  <= '0;
      r_right_hold <= '0;
      r_left_ok    <= 1'b0;
      r_armed      <= 1'b0;
      r_lrck_last  <= 1'b0;
      r_pair_pend  <= 1'b0;
    end else begin
      r_pair_pend <= 1'b0;
      if (!en) r_armed <= 1'b0;
      if (w_bclk_rise) begin
        r_lrck_last <= r_lrck_s2;
        if (w_lrck_edge) begin
          // Bit at the edge is the I2S delay slot and is discarded.
          r_state   <= ST_SHIFT;
          r_bit_cnt <= '0;
          r_chan    <= r_lrck_s2;
          // A word cut short poisons the current frame.
          if (r_state == ST_SHIFT) r_armed <= 1'b0;
          // Left start opens a new frame; re-arm only if enabled now, so a
          // left word that began before enable never forms a pair.
          if (!r_lrck_s2) begin
            r_left_ok <= 1'b0;
            if (en) r_armed <= 1'b1;
          end
        end else if (r_state == ST_SHIFT) begin
          r_shift   <= w_word;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == LP_LAST) begin
            r_state <= ST_FULL;
            if (!r_chan) begin
              r_left_hold <= w_word;
              r_left_ok   <= 1'b1;
            end else begin
              r_right_hold <= w_word;
              r_pair_pend  <= r_armed & r_left_ok & en;
            end
          end
        end
      end
    end
  end

  assign w_load    = r_pair_pend & en & (~o_valid | i_ready);
  assign w_ovf_set = r_pair_pend & en & o_valid & ~i_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_left  <= '0;
      o_right <= '0;
      o_valid <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (w_load) begin
        o_left  <= r_left_hold;
        o_right <= r_right_hold;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // Set has priority over a simultaneous clear.
      ovf <= w_ovf_set | (ovf & ~ovf_clr);
    end
  end

`ifdef AUDIO_ADC_RX_MONO_EN
  logic [DATA_W:0] w_left_ext;
  logic [DATA_W:0] w_right_ext;

  assign w_left_ext  = {r_left_hold[DATA_W-1], r_left_hold};
  assign w_right_ext = {r_right_hold[DATA_W-1], r_right_hold};

  // Sign-extended sum, then drop the LSB: arithmetic average truncated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_mono <= '0;
    end else if (w_load) begin
      o_mono <= DATA_W'((w_left_ext + w_right_ext) >> 1);
    end
  end
`else
  assign o_mono = '0;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
module tb_audio_adc_rx;

  logic        clk;
  logic        reset;
  logic        en;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic [15:0] o_left;
  logic [15:0] o_right;
  logic [15:0] o_mono;
  logic        o_valid;
  logic        i_ready;
  logic        ovf;
  logic        ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  audio_adc_rx #(.DATA_W(16), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_mono      (o_mono),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  // Posedges at 5,15,25...; all stimulus and sampling happens on multiples of 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    #40 AUD_BCLK = 1'b1;
    #40 AUD_BCLK = 1'b0;
  endtask

  // Delay slot, nbits MSB-first data bits, then pad trailing bits.
  task automatic send_word(input logic lr, input logic [15:0] w, input int nbits,
                           input int en_at, input int pad);
    send_bit(lr, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == en_at) en = 1'b1;
      send_bit(lr, w[15-i]);
    end
    for (int i = 0; i < pad; i++) send_bit(lr, 1'b1);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, l, 16, -1, 1);
    send_word(1'b1, r, 16, -1, 1);
  endtask

  // Last data bit with i_ready raised for exactly the clk that loads the pair
  // (rise at T, synchronizers + capture put the load at posedge T+35).
  task automatic last_bit_ready(input logic lr, input logic d);
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    #40 AUD_BCLK = 1'b1;
    #30 i_ready  = 1'b1;
    #10 i_ready  = 1'b0;
    AUD_BCLK = 1'b0;
    #30;
  endtask

  task automatic pulse_ready();
    i_ready = 1'b1;
    #10 i_ready = 1'b0;
    #10;
  endtask

  logic [15:0] exp_mono_a;
  logic [15:0] exp_mono_b;

  initial begin
`ifdef AUDIO_ADC_RX_MONO_EN
    exp_mono_a = 16'h4000;
    exp_mono_b = 16'hBFFF;
`else
    exp_mono_a = 16'h0000;
    exp_mono_b = 16'h0000;
`endif
    reset = 1'b0; en = 1'b0; i_ready = 1'b0; ovf_clr = 1'b0;
    AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;

    // Reset held with BCLK running
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
    chk_eq("rst_left",  o_left,  0);
    chk_eq("rst_right", o_right, 0);
    chk_eq("rst_mono",  o_mono,  0);
    chk_eq("rst_valid", o_valid, 0);
    chk_eq("rst_ovf",   ovf,     0);

    // First pair
    reset = 1'b1; en = 1'b1;
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_frame(16'h1234, 16'hABCD);
    chk_eq("p1_valid", o_valid, 1);
    chk_eq("p1_left",  o_left,  16'h1234);
    chk_eq("p1_right", o_right, 16'hABCD);
    chk_eq("p1_ovf",   ovf,     0);
    #200;
    chk_eq("p1_hold_valid", o_valid, 1);
    chk_eq("p1_hold_left",  o_left,  16'h1234);
    pulse_ready();
    chk_eq("p1_taken", o_valid, 0);

    // Enable asserted in the middle of a left word
    en = 1'b0;
    #20;
    send_word(1'b0, 16'h0001, 16, 8, 1);
    send_word(1'b1, 16'h0002, 16, -1, 1);
    chk_eq("enmid_no_pair", o_valid, 0);
    send_frame(16'h0003, 16'h0004);
    chk_eq("enmid_valid", o_valid, 1);
    chk_eq("enmid_left",  o_left,  16'h0003);
    chk_eq("enmid_right", o_right, 16'h0004);
    pulse_ready();

    // Backpressure -> overflow
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    chk_eq("bp_valid", o_valid, 1);
    chk_eq("bp_left",  o_left,  16'h1111);
    chk_eq("bp_right", o_right, 16'h2222);
    chk_eq("bp_ovf",   ovf,     1);
    ovf_clr = 1'b1;
    #10 ovf_clr = 1'b0;
    #10;
    chk_eq("bp_ovf_clr", ovf, 0);
    chk_eq("bp_valid_after_clr", o_valid, 1);
    pulse_ready();
    chk_eq("bp_taken", o_valid, 0);

    // Short left word (10 bits)
    send_word(1'b0, 16'hFFFF, 10, -1, 0);
    send_word(1'b1, 16'h5555, 16, -1, 1);
    chk_eq("short_no_pair", o_valid, 0);
    send_frame(16'h6666, 16'h7777);
    chk_eq("short_next_valid", o_valid, 1);
    chk_eq("short_next_left",  o_left,  16'h6666);
    chk_eq("short_next_right", o_right, 16'h7777);

    // Simultaneous: pending pair read in the same cycle a new pair loads
    send_word(1'b0, 16'h0C0C, 16, -1, 1);
    send_word(1'b1, 16'h0D0D, 15, -1, 0);
    last_bit_ready(1'b1, 1'b1);
    chk_eq("simul_valid", o_valid, 1);
    chk_eq("simul_left",  o_left,  16'h0C0C);
    chk_eq("simul_right", o_right, 16'h0D0D);
    chk_eq("simul_ovf",   ovf,     0);
    pulse_ready();
    chk_eq("simul_taken", o_valid, 0);

    // Disabled: no pair loaded
    en = 1'b0;
    send_frame(16'h1357, 16'h2468);
    chk_eq("dis_no_pair", o_valid, 0);
    chk_eq("dis_left",    o_left,  16'h0C0C);
    en = 1'b1;

    // Mono mix
    send_frame(16'h7FFF, 16'h0001);
    chk_eq("mono_a_valid", o_valid, 1);
    chk_eq("mono_a", o_mono, {16'h0, exp_mono_a});
    pulse_ready();
    send_frame(16'h8000, 16'hFFFF);
    chk_eq("mono_b_left", o_left, 16'h8000);
    chk_eq("mono_b", o_mono, {16'h0, exp_mono_b});

    // Reset mid-word with a pair still pending
    send_word(1'b0, 16'hAAAA, 8, -1, 0);
    reset = 1'b0;
    #20;
    chk_eq("rmid_valid", o_valid, 0);
    chk_eq("rmid_left",  o_left,  0);
    reset = 1'b1;
    #20;
    send_bit(1'b1, 1'b0);
    send_frame(16'h0F0F, 16'hF0F0);
    chk_eq("rmid_after_valid", o_valid, 1);
    chk_eq("rmid_after_left",  o_left,  16'h0F0F);
    chk_eq("rmid_after_right", o_right, 16'hF0F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
